data_memory_sync: RTL
=====================

DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data and address word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 10, index width; DEPTH = 2**ADDR_BITS entries; ADDR_BITS <= WORD_SIZE.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port memaddr  input  WORD_SIZE  word address; index = memaddr[ADDR_BITS-1:0].
REQ-006 SHALL have port memval  input  WORD_SIZE  write data.
REQ-007 SHALL have port memget  input  1  read request, sampled on clk edge.
REQ-008 SHALL have port memset  input  1  write request, sampled on clk edge.
REQ-009 SHALL have port memclr  input  1  clear-all request, sampled on clk edge.
REQ-010 SHALL have port memout  output  WORD_SIZE  registered read data.
REQ-011 SHALL have port memvalid  output  1  one-cycle pulse: memout updated by a read.
REQ-012 SHALL have port membusy  output  1  high while a clear sweep is running.
REQ-013 SHALL have port memerr  output  1  one-cycle pulse: out-of-range access (see Configuration).

Function
REQ-014 SHALL implement two states, IDLE and CLEAR; requests are accepted only in IDLE.
REQ-015 SHALL, in IDLE, apply priority memclr > memset > memget; lower-priority requests in the same cycle are dropped.
REQ-016 SHALL, on memset in IDLE, write memval to data[index] at that edge; memvalid stays 0.
REQ-017 SHALL, on memget in IDLE, load data[index] into memout at that edge and assert memvalid for exactly that following cycle (latency 1).
REQ-018 SHALL hold memout unchanged between reads; back-to-back reads produce one memvalid pulse per cycle.
REQ-019 SHALL return the newly written value when a read follows a write to the same index on the next cycle.
REQ-020 SHALL, on memclr in IDLE, enter CLEAR with a sweep counter at 0, writing 0 to data[counter] on each edge and incrementing by 1.
REQ-021 SHALL assert membusy on the cycle after memclr is accepted and hold it for exactly DEPTH cycles; after writing index DEPTH-1, return to IDLE with counter 0 and membusy low.
REQ-022 SHALL ignore memget, memset and memclr while in CLEAR: no writes, no memvalid, no memerr.
REQ-023 SHALL leave memout unchanged during and after a clear sweep.

Reset
REQ-024 SHALL, on rst_n low, immediately force memout=0, memvalid=0, membusy=0, memerr=0, state=IDLE, sweep counter=0.
REQ-025 SHALL NOT reset the storage array; contents are undefined after power-up until written or cleared.
REQ-026 SHALL abort a clear sweep on reset; entries already swept stay 0, the rest keep prior contents.

Configuration
REQ-027 SHALL compile bounds checking in when macro DMEM_BOUNDS_CHECK_EN is defined: any request with memaddr[WORD_SIZE-1:ADDR_BITS] nonzero is out of range.
REQ-028 SHALL, with DMEM_BOUNDS_CHECK_EN, suppress out-of-range writes and pulse memerr for one cycle; out-of-range reads load memout=0, pulse memvalid and memerr together.
REQ-029 SHALL, without DMEM_BOUNDS_CHECK_EN, ignore upper address bits (address wraps modulo DEPTH) and tie memerr to 0.

Verification
REQ-030 SHALL cover: reset, memset addr 5 val 0x1234, next cycle memget addr 5 -> memout=0x1234, memvalid high exactly one cycle.
REQ-031 SHALL cover: memset and memget both high, addr 7 val 0x00FF -> data[7]=0x00FF, no memvalid pulse that cycle.
REQ-032 SHALL cover: memclr with ADDR_BITS=4 -> membusy high 16 cycles; memset during sweep ignored; reads of all 16 entries afterwards -> 0.
REQ-033 SHALL cover: rst_n low mid-sweep at counter 6 -> membusy=0 immediately; entries 0..5 read 0, entries 6..15 keep prior values.
REQ-034 SHALL cover: with DMEM_BOUNDS_CHECK_EN and ADDR_BITS=10, memget addr 0x0400 -> memout=0, memvalid=1, memerr=1; memset addr 0x0400 -> data[0] unchanged, memerr=1.
REQ-035 SHALL cover: without DMEM_BOUNDS_CHECK_EN, memset addr 0x0403 val 9 then memget addr 3 -> memout=9, memerr never asserted.

Source files
------------

// File: rtl/data_memory_sync.sv
// Single-port synchronous data memory with 1-cycle registered reads and a
// DEPTH-cycle clear sweep. Optional address bounds checking: DMEM_BOUNDS_CHECK_EN.
module data_memory_sync #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] memaddr,
   input  logic [WORD_SIZE-1:0] memval,
   input  logic                 memget,
   input  logic                 memset,
   input  logic                 memclr,
   output logic [WORD_SIZE-1:0] memout,
   output logic                 memvalid,
   output logic                 membusy,
   output logic                 memerr
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t               state_q;
   logic [ADDR_BITS-1:0] cnt_q;
   logic [WORD_SIZE-1:0] memout_q;
   logic                 memvalid_q;
   logic                 membusy_q;
   logic                 memerr_q;
   logic [WORD_SIZE-1:0] mem_q [DEPTH];

   logic [ADDR_BITS-1:0] idx;
   logic                 oor;
   logic                 idle;
   logic                 do_clr;
   logic                 do_set;
   logic                 do_get;
   logic                 mem_we_d;
   logic [ADDR_BITS-1:0] mem_widx_d;
   logic [WORD_SIZE-1:0] mem_wdata_d;
   logic                 unused_addr;

   assign idx         = memaddr[ADDR_BITS-1:0];
   assign unused_addr = ^memaddr;

`ifdef DMEM_BOUNDS_CHECK_EN
   generate
      if (ADDR_BITS < WORD_SIZE) begin : g_bounds
         assign oor = |memaddr[WORD_SIZE-1:ADDR_BITS];
      end else begin : g_no_bounds
         assign oor = 1'b0;
      end
   endgenerate
`else
   assign oor = 1'b0;
`endif

   // Requests are only honoured in IDLE, with clear > set > get.
   assign idle   = (state_q == S_IDLE);
   assign do_clr = idle & memclr;
   assign do_set = idle & ~memclr & memset;
   assign do_get = idle & ~memclr & ~memset & memget;

   always_comb begin
      mem_we_d    = 1'b0;
      mem_widx_d  = idx;
      mem_wdata_d = memval;
      if (state_q == S_CLEAR) begin
         mem_we_d    = 1'b1;
         mem_widx_d  = cnt_q;
         mem_wdata_d = '0;
      end else if (do_set && !oor) begin
         mem_we_d = 1'b1;
      end
   end

   // Storage has no reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (mem_we_d && rst_n) begin
         mem_q[mem_widx_d] <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         memout_q   <= '0;
         memvalid_q <= 1'b0;
         membusy_q  <= 1'b0;
         memerr_q   <= 1'b0;
      end else begin
         memvalid_q <= 1'b0;
         memerr_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (do_clr) begin
                  state_q   <= S_CLEAR;
                  cnt_q     <= '0;
                  membusy_q <= 1'b1;
               end else if (do_set) begin
                  memerr_q <= oor;
               end else if (do_get) begin
                  memout_q   <= oor ? '0 : mem_q[idx];
                  memvalid_q <= 1'b1;
                  memerr_q   <= oor;
               end
            end
            S_CLEAR: begin
               if (&cnt_q) begin
                  state_q   <= S_IDLE;
                  cnt_q     <= '0;
                  membusy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign memout   = memout_q;
   assign memvalid = memvalid_q;
   assign membusy  = membusy_q;
   assign memerr   = memerr_q;

endmodule
